// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing constants, layout mode codes and scan-out pipeline flag type
package vga_pkg;
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FRONT_DEF  = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BACK_DEF   = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FRONT_DEF  = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BACK_DEF   = 33;
  localparam int MODE_PAGE    = 0;
  localparam int MODE_LINEAR  = 1;
  typedef struct packed {
    logic       act;
    logic       hs;
    logic       vs;
    logic       fs;
    logic [2:0] row;
  } flags_t;
  function automatic int total(input int a, input int b, input int c, input int d);
    return a + b + c + d;
  endfunction
endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running h/v counters with active, sync and frame-start flags
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FRONT  = H_FRONT_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BACK   = H_BACK_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FRONT  = V_FRONT_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BACK   = V_BACK_DEF,
  parameter int HW       = $clog2(total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK)),
  parameter int VW       = $clog2(total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK))
) (
  input  logic          Clock,
  input  logic          Reset,
  output logic [HW-1:0] h_count,
  output logic [VW-1:0] v_count,
  output logic          act,
  output logic          hs,
  output logic          vs,
  output logic          frame_start
);
  localparam int H_TOTAL = total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
  logic [31:0] hc, vc;
  logic        h_last, v_last;
  assign hc          = 32'(h_count);
  assign vc          = 32'(v_count);
  assign h_last      = hc == H_TOTAL - 1;
  assign v_last      = vc == V_TOTAL - 1;
  assign act         = hc < H_ACTIVE && vc < V_ACTIVE;
  assign hs          = hc >= H_ACTIVE + H_FRONT && hc < H_ACTIVE + H_FRONT + H_SYNC;
  assign vs          = vc >= V_ACTIVE + V_FRONT && vc < V_ACTIVE + V_FRONT + V_SYNC;
  assign frame_start = hc == 0 && vc == 0;
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) begin
      h_count <= '0;
      v_count <= '0;
    end else begin
      h_count <= h_last ? '0 : h_count + 1'b1;
      if (h_last) v_count <= v_last ? '0 : v_count + 1'b1;
    end
endmodule

// File: rtl/vga_fb_scanout.sv
// vga_fb_scanout: VGA scan-out reading a byte-wide framebuffer, with integer up-scaling and page/linear layouts
module vga_fb_scanout
  import vga_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int H_FRONT     = H_FRONT_DEF,
  parameter int H_SYNC      = H_SYNC_DEF,
  parameter int H_BACK      = H_BACK_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int V_FRONT     = V_FRONT_DEF,
  parameter int V_SYNC      = V_SYNC_DEF,
  parameter int V_BACK      = V_BACK_DEF,
  parameter int SCALE_LOG2  = 2,
  parameter int MODE        = MODE_PAGE,
  parameter int RAM_LATENCY = 1,
  parameter bit SYNC_POL    = 1'b0,
  parameter int ADDR_W      = 12
) (
  input  logic              Clock,
  input  logic              Reset,
  output logic [ADDR_W-1:0] Address_o,
  input  logic [7:0]        Data_i,
  output logic              Red_o,
  output logic              Green_o,
  output logic              Blue_o,
  output logic              HSync_o,
  output logic              VSync_o,
  output logic              FrameStart_o,
  output logic              Active_o
);
  localparam int HW   = $clog2(total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK));
  localparam int VW   = $clog2(total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK));
  localparam int D    = RAM_LATENCY + 1;
  localparam int W    = H_ACTIVE >> SCALE_LOG2;
  localparam int ROWS = MODE == MODE_PAGE ? (V_ACTIVE >> SCALE_LOG2) >> 3 : V_ACTIVE >> SCALE_LOG2;
  if (H_ACTIVE % (1 << SCALE_LOG2) != 0 || V_ACTIVE % (1 << SCALE_LOG2) != 0 ||
      (MODE == MODE_PAGE && (V_ACTIVE >> SCALE_LOG2) % 8 != 0) ||
      longint'(ROWS) * longint'(W) > (64'd1 << ADDR_W) ||
      SCALE_LOG2 < 0 || SCALE_LOG2 > 3 || RAM_LATENCY < 1 || RAM_LATENCY > 3) begin : g_illegal
    $error("vga_fb_scanout: illegal parameter combination");
  end
  logic [HW-1:0]     h_count;
  logic [VW-1:0]     v_count;
  logic              act, hs, vs, fs;
  logic [31:0]       hpix, vpix;
  logic [ADDR_W-1:0] addr0;
  flags_t            f0, fl;
  flags_t            pipe [D];
  logic [2:0]        pix;
  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
    .HW(HW), .VW(VW)
  ) u_timing (
    .Clock(Clock), .Reset(Reset), .h_count(h_count), .v_count(v_count),
    .act(act), .hs(hs), .vs(vs), .frame_start(fs)
  );
  assign hpix  = 32'(h_count) >> SCALE_LOG2;
  assign vpix  = 32'(v_count) >> SCALE_LOG2;
  assign addr0 = ADDR_W'((MODE == MODE_PAGE ? vpix >> 3 : vpix) * 32'(W) + hpix);
  assign f0    = {act, hs, vs, fs, vpix[2:0]};
  assign fl    = pipe[D-1];
  // Page mode picks the bit for this pixel's row within the 8-row byte column
  assign pix   = MODE == MODE_LINEAR ? Data_i[2:0] : {3{Data_i[fl.row]}};
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) begin
      Address_o <= '0;
      for (int i = 0; i < D; i++) pipe[i] <= '0;
    end else begin
      Address_o <= act ? addr0 : '0;
      pipe[0]   <= f0;
      for (int i = 1; i < D; i++) pipe[i] <= pipe[i-1];
    end
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) begin
      {Red_o, Green_o, Blue_o} <= 3'b000;
      HSync_o                  <= ~SYNC_POL;
      VSync_o                  <= ~SYNC_POL;
      FrameStart_o             <= 1'b0;
      Active_o                 <= 1'b0;
    end else begin
      {Red_o, Green_o, Blue_o} <= fl.act ? pix : 3'b000;
      HSync_o                  <= fl.hs ? SYNC_POL : ~SYNC_POL;
      VSync_o                  <= fl.vs ? SYNC_POL : ~SYNC_POL;
      FrameStart_o             <= fl.fs;
      Active_o                 <= fl.act;
    end
endmodule
